spikehard_dma_rd_arbiter: RTL and testbench

SPIKEHARD_DMA_RD_ARBITER -- requirements
Module: spikehard_dma_rd_arbiter

---
 rtl/spikehard_dma_rd_arbiter_pkg.sv | 19 +
 rtl/spikehard_rr_arb2.sv | 34 +++
 rtl/spikehard_dma_rd_arbiter.sv | 116 +++++++++++
 tb/tb_spikehard_dma_rd_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spikehard_dma_rd_arbiter_pkg.sv
// Shared types and constants for the SpikeHard DMA read arbiter.
// Holds the FSM state encoding, DMA beat-size codes and requester count.
package spikehard_dma_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CTRL = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [2:0] DMA_SIZE_32 = 3'b010;
  localparam logic [2:0] DMA_SIZE_64 = 3'b011;
  localparam int NUM_REQ = 2;

  function automatic logic [2:0] dma_size(input int width);
    return (width == 64) ? DMA_SIZE_64 : DMA_SIZE_32;
  endfunction

endpackage

// File: rtl/spikehard_rr_arb2.sv
// Two-way arbiter: round-robin pointer by default, fixed priority to requester 0
// when SPIKEHARD_DMA_ARB_FIXED_PRIO_EN is defined (pointer register removed).
module spikehard_rr_arb2
  import spikehard_dma_rd_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  input  logic               served,
  output logic [NUM_REQ-1:0] grant,
  output logic               winner
);

`ifdef SPIKEHARD_DMA_ARB_FIXED_PRIO_EN
  assign winner = ~req[0] & req[1];
`else
  logic ptr;

  // After a completed grant the other requester gets priority on the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (update) begin
      ptr <= ~served;
    end
  end

  assign winner = (req == 2'b11) ? ptr : (req[1] & ~req[0]);
`endif

  assign grant = (req != '0) ? (winner ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: rtl/spikehard_dma_rd_arbiter.sv
// Arbitrates two DMA read requesters onto one DMA ctrl/data channel pair.
// Policy selected by SPIKEHARD_DMA_ARB_FIXED_PRIO_EN (default: round-robin).
module spikehard_dma_rd_arbiter
  import spikehard_dma_rd_arbiter_pkg::*;
#(
  parameter int DMA_BUS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [32*NUM_REQ-1:0]    req_index,
  input  logic [32*NUM_REQ-1:0]    req_length,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [DMA_BUS_WIDTH-1:0] rd_data,
  output logic [NUM_REQ-1:0]       rd_valid,
  input  logic [NUM_REQ-1:0]       rd_ready,
  output logic                     rd_last,
  output logic                     dma_read_ctrl_valid,
  input  logic                     dma_read_ctrl_ready,
  output logic [31:0]              dma_read_ctrl_data_index,
  output logic [31:0]              dma_read_ctrl_data_length,
  output logic [2:0]               dma_read_ctrl_data_size,
  input  logic                     dma_read_chnl_valid,
  output logic                     dma_read_chnl_ready,
  input  logic [DMA_BUS_WIDTH-1:0] dma_read_chnl_data,
  output logic                     busy
);

  state_t state;
  logic          gnt_id;
  logic [31:0]   index_q;
  logic [31:0]   length_q;
  logic [31:0]   count;

  logic [NUM_REQ-1:0] arb_grant;
  logic          arb_winner;
  logic          idle;
  logic          in_data;
  logic          accept;
  logic          zero_len;
  logic          beat;
  logic          last_beat;
  logic          arb_update;
  logic          arb_served;
  logic [31:0]   win_index;
  logic [31:0]   win_length;

  assign idle       = (state == IDLE);
  assign in_data    = (state == DATA);
  assign accept     = idle & (|req_valid);
  assign win_index  = arb_winner ? req_index[63:32]  : req_index[31:0];
  assign win_length = arb_winner ? req_length[63:32] : req_length[31:0];
  assign zero_len   = (win_length == 32'd0);
  assign beat       = in_data & dma_read_chnl_valid & dma_read_chnl_ready;
  assign last_beat  = beat & (count == 32'd1);

  // Zero-length accepts finish in IDLE, so they rotate priority immediately.
  assign arb_update = (accept & zero_len) | last_beat;
  assign arb_served = idle ? arb_winner : gnt_id;

  spikehard_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .update (arb_update),
    .served (arb_served),
    .grant  (arb_grant),
    .winner (arb_winner)
  );

  assign req_ready                 = idle ? arb_grant : '0;
  assign dma_read_ctrl_valid       = (state == CTRL);
  assign dma_read_ctrl_data_index  = index_q;
  assign dma_read_ctrl_data_length = length_q;
  assign dma_read_ctrl_data_size   = dma_size(DMA_BUS_WIDTH);
  assign rd_data                   = in_data ? dma_read_chnl_data : '0;
  assign rd_valid                  = (in_data & dma_read_chnl_valid) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign dma_read_chnl_ready       = in_data & rd_ready[gnt_id];
  assign rd_last                   = in_data & (count == 32'd1);
  assign busy                      = ~idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt_id   <= 1'b0;
      index_q  <= '0;
      length_q <= '0;
      count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            gnt_id   <= arb_winner;
            index_q  <= win_index;
            length_q <= win_length;
            if (!zero_len) state <= CTRL;
          end
        end
        CTRL: begin
          if (dma_read_ctrl_ready) begin
            state <= DATA;
            count <= length_q;
          end
        end
        DATA: begin
          if (beat) begin
            count <= count - 32'd1;
            if (count == 32'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spikehard_dma_rd_arbiter.sv
// Scoreboard bench: reference arbitration model queues expected grants, ctrl
// words and beats; a negedge monitor pops and compares whenever the DUT shows them.
`timescale 1ns/1ps
module tb_spikehard_dma_rd_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid;
  logic [63:0]  req_index;
  logic [63:0]  req_length;
  logic [1:0]   req_ready;
  logic [W-1:0] rd_data;
  logic [1:0]   rd_valid;
  logic [1:0]   rd_ready;
  logic         rd_last;
  logic         ctrl_valid;
  logic         ctrl_ready;
  logic [31:0]  ctrl_index;
  logic [31:0]  ctrl_length;
  logic [2:0]   ctrl_size;
  logic         chnl_valid;
  logic         chnl_ready;
  logic [W-1:0] chnl_data;
  logic         busy;

  always #5 clk = ~clk;

  spikehard_dma_rd_arbiter #(.DMA_BUS_WIDTH(W)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .req_valid                 (req_valid),
    .req_index                 (req_index),
    .req_length                (req_length),
    .req_ready                 (req_ready),
    .rd_data                   (rd_data),
    .rd_valid                  (rd_valid),
    .rd_ready                  (rd_ready),
    .rd_last                   (rd_last),
    .dma_read_ctrl_valid       (ctrl_valid),
    .dma_read_ctrl_ready       (ctrl_ready),
    .dma_read_ctrl_data_index  (ctrl_index),
    .dma_read_ctrl_data_length (ctrl_length),
    .dma_read_ctrl_data_size   (ctrl_size),
    .dma_read_chnl_valid       (chnl_valid),
    .dma_read_chnl_ready       (chnl_ready),
    .dma_read_chnl_data        (chnl_data),
    .busy                      (busy)
  );

  typedef struct {
    int           req;
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  int vectors = 0;
  int miscompares = 0;
  int exp_grant_q[$];
  logic [31:0] exp_idx_q[$];
  logic [31:0] exp_len_q[$];
  beat_t exp_beat_q[$];
  logic [W-1:0] dma_data_q[$];
  int  model_ptr = 0;
  int  beats_seen = 0;
  bit  mon_en = 0;
  bit  full_rate = 0;
  bit  stall_ctrl = 0;
  bit  dma_hs = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    int g;
    beat_t b;
    logic [31:0] ei, el;
    dma_hs = chnl_valid & chnl_ready;
    if (mon_en) begin
      if (req_ready != 2'b00) begin
        if (exp_grant_q.size() == 0) check("unexpected_accept", req_ready, 0);
        else begin
          g = exp_grant_q.pop_front();
          check("grant", req_ready, 2'b01 << g);
        end
      end
      if (ctrl_valid && ctrl_ready) begin
        if (exp_idx_q.size() == 0) check("unexpected_ctrl", ctrl_valid, 0);
        else begin
          ei = exp_idx_q.pop_front();
          el = exp_len_q.pop_front();
          check("ctrl_index", ctrl_index, ei);
          check("ctrl_length", ctrl_length, el);
          check("ctrl_size", ctrl_size, 3'b010);
        end
      end
      if ((rd_valid & rd_ready) != 2'b00) begin
        if (exp_beat_q.size() == 0) check("unexpected_beat", rd_valid, 0);
        else begin
          b = exp_beat_q.pop_front();
          check("beat_req", rd_valid, 2'b01 << b.req);
          check("beat_data", rd_data, b.data);
          check("beat_last", rd_last, b.last);
          beats_seen++;
        end
      end
    end
  end

  // DMA and consumer side: random backpressure, data held until accepted.
  initial begin
    ctrl_ready = 0; chnl_valid = 0; chnl_data = '0; rd_ready = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (dma_hs && dma_data_q.size() > 0) void'(dma_data_q.pop_front());
      chnl_valid = (dma_data_q.size() > 0) && (full_rate || $urandom_range(3) != 0);
      chnl_data  = (dma_data_q.size() > 0) ? dma_data_q[0] : '0;
      ctrl_ready = !stall_ctrl && (full_rate || $urandom_range(1) == 1);
      rd_ready   = full_rate ? 2'b11 : 2'($urandom_range(3));
    end
  end

  task automatic predict(input logic [1:0] mask, input logic [31:0] i0, input logic [31:0] l0,
                         input logic [31:0] i1, input logic [31:0] l1,
                         output int w, output logic [31:0] wi, output logic [31:0] wl);
`ifdef SPIKEHARD_DMA_ARB_FIXED_PRIO_EN
    w = mask[0] ? 0 : 1;
`else
    w = (mask == 2'b11) ? model_ptr : (mask[0] ? 0 : 1);
`endif
    wi = (w == 1) ? i1 : i0;
    wl = (w == 1) ? l1 : l0;
    exp_grant_q.push_back(w);
    if (wl != 0) begin
      exp_idx_q.push_back(wi);
      exp_len_q.push_back(wl);
      for (int k = 0; k < int'(wl); k++) begin
        beat_t nb;
        nb.req  = w;
        nb.data = W'($urandom);
        nb.last = (k == int'(wl) - 1);
        dma_data_q.push_back(nb.data);
        exp_beat_q.push_back(nb);
      end
    end
    model_ptr = 1 - w;
  endtask

  task automatic present(input logic [1:0] mask, input logic [31:0] i0, input logic [31:0] l0,
                         input logic [31:0] i1, input logic [31:0] l1);
    int n;
    @(posedge clk);
    #1;
    req_valid  = mask;
    req_index  = {i1, i0};
    req_length = {l1, l0};
    n = 0;
    @(negedge clk);
    while (req_ready == 2'b00 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("accept_timeout", req_ready, mask);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || exp_beat_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("idle_timeout", busy, 0);
  endtask

  task automatic issue(input logic [1:0] mask, input logic [31:0] i0, input logic [31:0] l0,
                       input logic [31:0] i1, input logic [31:0] l1, input int stall);
    int w;
    logic [31:0] wi, wl;
    predict(mask, i0, l0, i1, l1, w, wi, wl);
    stall_ctrl = (stall > 0);
    present(mask, i0, l0, i1, l1);
    @(negedge clk);
    if (wl == 0) begin
      check("zero_len_busy", busy, 0);
      check("zero_len_ctrl", ctrl_valid, 0);
    end else begin
      check("ctrl_after_accept", ctrl_valid, 1);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check("stall_ctrl_valid", ctrl_valid, 1);
        check("stall_index", ctrl_index, wi);
        check("stall_length", ctrl_length, wl);
      end
    end
    stall_ctrl = 0;
    wait_idle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ctrl_valid"}, ctrl_valid, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_last"}, rd_last, 0);
    check({tag, "_chnl_ready"}, chnl_ready, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_ctrl_index"}, ctrl_index, 0);
    check({tag, "_ctrl_length"}, ctrl_length, 0);
    check({tag, "_ctrl_size"}, ctrl_size, 3'b010);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start, n;
    logic [1:0] m;
    rst = 1; req_valid = 0; req_index = '0; req_length = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 0;
    mon_en = 1;

    // Both requesters contending right out of reset.
    for (int r = 0; r < 4; r++)
      issue(2'b11, 32'h1000 + r, 32'd2, 32'h2000 + r, 32'd2, 0);

    full_rate = 1;
    issue(2'b01, 32'h100, 32'd4, 32'h0, 32'd0, 0);
    full_rate = 0;

    issue(2'b10, 32'h0, 32'd0, 32'h55, 32'd0, 0);
    issue(2'b01, 32'hABC, 32'd6, 32'h0, 32'd0, 5);

    for (int t = 0; t < 40; t++) begin
      m = 2'($urandom_range(1, 3));
      issue(m, $urandom, 32'($urandom_range(0, 6)), $urandom, 32'($urandom_range(0, 6)),
            ($urandom_range(3) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    // Abandon a length-8 transfer mid-stream with a synchronous reset.
    predict(2'b01, 32'h800, 32'd8, 32'h0, 32'd0, n, start, start);
    present(2'b01, 32'h800, 32'd8, 32'h0, 32'd0);
    start = beats_seen;
    n = 0;
    while (beats_seen < start + 1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("mid_reset_beat_timeout", beats_seen, start + 1);
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check_all_zero("mid_reset");
    exp_beat_q.delete();
    model_ptr = 0;
    repeat (4) begin
      @(negedge clk);
      check("stray_chnl_ready", chnl_ready, 0);
      check("stray_rd_valid", rd_valid, 0);
    end
    dma_data_q.delete();
    issue(2'b01, 32'h900, 32'd1, 32'h0, 32'd0, 0);

    check("leftover_grants", exp_grant_q.size(), 0);
    check("leftover_ctrl", exp_idx_q.size(), 0);
    check("leftover_beats", exp_beat_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
